result_checker: RTL and testbench
=================================

// Module: result_checker
// PURPOSE
// - Synthesizable, parametrised golden-result checker for BNN netlist bring-up.
// - Compares NUM_CH DUT result channels, beat by beat, against a loadable golden
//   memory of DEPTH vectors; reports pass/fail, error count and first mismatch.
// - Sits beside the DUT top in simulation and on-board self-test; replaces
//   hand-written per-signal pass flags.
// PARAMETERS
// - NUM_CH      2     number of compared result channels
// - DATA_W      16    bits per channel
// - DEPTH       16    golden vectors per run (>=1)
// - SETTLE_CYC  2     cycles after start before beats are accepted (0 allowed)
// - TIMEOUT     1024  max idle cycles between beats in CHECK (>=1)
// - STOP_ON_ERR 0     1: finish run at first mismatching beat
// PORTS
// - clk           in   1                 clock, all logic on rising edge
// - rst           in   1                 asynchronous, active-high reset
// - start         in   1                 pulse: begin a run (honoured in IDLE/DONE only)
// - obs_valid     in   1                 DUT result beat valid
// - obs_data      in   NUM_CH*DATA_W     DUT results, ch0 in LSBs
// - exp_wr_en     in   1                 golden memory write strobe
// - exp_wr_addr   in   $clog2(DEPTH)     golden write address
// - exp_wr_data   in   NUM_CH*DATA_W     golden vector
// - busy          out  1                 SETTLE or CHECK
// - done          out  1                 run finished (level, until next start)
// - pass          out  1                 done and zero mismatches and no timeout
// - timeout       out  1                 run ended by TIMEOUT
// - err_count     out  $clog2(DEPTH+1)   mismatching beats (saturating at DEPTH)
// - first_err_idx out  $clog2(DEPTH)     beat index of first mismatch
// - first_err_ch  out  $clog2(NUM_CH)+1  lowest mismatching channel of that beat
// BEHAVIOUR
// - Reset: FSM=IDLE; busy/done/pass/timeout=0; err_count, first_err_*=0; memory
//   contents not reset. rst mid-run aborts immediately to IDLE.
// - FSM: IDLE -start-> SETTLE; SETTLE (count SETTLE_CYC, skip if 0) -> CHECK;
//   CHECK -> DONE on DEPTH-th beat, on TIMEOUT idle cycles, or (STOP_ON_ERR)
//   first mismatch; DONE -start-> SETTLE (re-run, stats cleared on start).
// - start in SETTLE/CHECK ignored. obs_valid outside CHECK ignored.
// - Beat k (0-based, k=beat counter) compared with mem[k], all channels in the
//   same cycle; mismatch = any channel differs. Result registered: err_count,
//   first_err_*, done/pass visible 1 cycle after the deciding beat.
// - first_err_* captured only on first mismatch; first_err_ch = lowest index.
// - Timeout counter clears on every accepted beat and on entry to CHECK;
//   reaching TIMEOUT -> DONE, timeout=1, pass=0.
// - Golden writes accepted in IDLE/DONE only; ignored when busy. Write and start
//   in same cycle: write lands; run uses updated memory (first read >=1 cycle later,
//   including SETTLE_CYC=0, since beats are accepted only in CHECK).
// - Beat counter wraps never: final beat index DEPTH-1 ends the run.
// STRUCTURE
// - Package chk_pkg: state enum {IDLE,SETTLE,CHECK,DONE}; width helper constants.
// - Sub-module golden_mem: DEPTH x NUM_CH*DATA_W, 1 write port, async read port
//   (distributed RAM); checker FSM, counters and comparators in top.
// TESTING
// - Load mem[i]={i+0x100,i}, start, feed matching beats 1/cycle -> done after
//   DEPTH beats +1 cycle, pass=1, err_count=0.
// - Corrupt ch1 of beat 5 and ch0 of beat 9 -> pass=0, err_count=2,
//   first_err_idx=5, first_err_ch=1.
// - STOP_ON_ERR=1, corrupt beat 3 -> done 1 cycle after beat 3, err_count=1.
// - Stop beats after 4 -> done exactly TIMEOUT cycles later, timeout=1, pass=0.
// - Assert rst during CHECK at beat 7 -> all outputs 0 next cycle, FSM IDLE;
//   restart without reload -> pass=1 (memory retained).
// - Issue start and exp_wr_en in CHECK -> both ignored; run result unchanged.

Source files
------------

// File: rtl/chk_pkg.sv
// Shared state encoding and width helpers for the golden-result checker.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } chk_state_e;

    // Address width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/golden_mem.sv
// Golden vector store: one synchronous write port, one asynchronous read port.
module golden_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset so a reload is not needed after rst.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/result_checker.sv
// Golden-result checker: compares NUM_CH result channels beat by beat against a
// loadable golden memory and reports pass/fail, error count and first mismatch.
module result_checker
    import chk_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  DATA_W      = 16,
    parameter int  DEPTH       = 16,
    parameter int  SETTLE_CYC  = 2,
    parameter int  TIMEOUT     = 1024,
    parameter int  STOP_ON_ERR = 0,
    localparam int VW          = NUM_CH * DATA_W,
    localparam int AW          = idx_w(DEPTH),
    localparam int CW          = cnt_w(DEPTH),
    localparam int CHW         = $clog2(NUM_CH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           obs_valid,
    input  logic [VW-1:0]  obs_data,
    input  logic           exp_wr_en,
    input  logic [AW-1:0]  exp_wr_addr,
    input  logic [VW-1:0]  exp_wr_data,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic           timeout,
    output logic [CW-1:0]  err_count,
    output logic [AW-1:0]  first_err_idx,
    output logic [CHW-1:0] first_err_ch
);

    localparam int SW = cnt_w(SETTLE_CYC);
    localparam int TW = cnt_w(TIMEOUT);

    chk_state_e     state_q, state_d;
    logic [AW-1:0]  beat_q;
    logic [SW-1:0]  settle_q;
    logic [TW-1:0]  idle_q;
    logic [CW-1:0]  err_q;
    logic [AW-1:0]  fidx_q;
    logic [CHW-1:0] fch_q;
    logic           to_q;

    logic [VW-1:0]     gold;
    logic [NUM_CH-1:0] ch_diff;
    logic [CHW-1:0]    low_ch;
    logic              start_ok, accept, mism, last_beat, idle_hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(DEPTH)) ? c : c + CW'(1);
    endfunction

    golden_mem #(
        .DEPTH (DEPTH),
        .WIDTH (VW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (exp_wr_en && !busy),
        .wr_addr (exp_wr_addr),
        .wr_data (exp_wr_data),
        .rd_addr (beat_q),
        .rd_data (gold)
    );

    // Compare stage: all channels of the current beat against mem[beat_q]
    always_comb begin
        ch_diff = '0;
        low_ch  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_diff[ch] = obs_data[ch*DATA_W +: DATA_W] != gold[ch*DATA_W +: DATA_W];
        end
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            if (ch_diff[ch]) low_ch = CHW'(ch);
        end
    end

    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign accept    = (state_q == CHECK) && obs_valid;
    assign mism      = accept && (|ch_diff);
    assign last_beat = accept && (beat_q == AW'(DEPTH - 1));
    assign idle_hit  = (state_q == CHECK) && !obs_valid && (idle_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = (SETTLE_CYC == 0) ? CHECK : SETTLE;
            SETTLE:     if (settle_q == SW'(SETTLE_CYC - 1)) state_d = CHECK;
            CHECK:      if (last_beat || idle_hit || (STOP_ON_ERR != 0 && mism)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result stage: counters and first-mismatch capture, visible the cycle after the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q   <= '0;
            settle_q <= '0;
            idle_q   <= '0;
            err_q    <= '0;
            fidx_q   <= '0;
            fch_q    <= '0;
            to_q     <= 1'b0;
        end else if (start_ok) begin
            beat_q   <= '0;
            settle_q <= '0;
            idle_q   <= '0;
            err_q    <= '0;
            fidx_q   <= '0;
            fch_q    <= '0;
            to_q     <= 1'b0;
        end else if (state_q == SETTLE) begin
            settle_q <= settle_q + SW'(1);
        end else if (accept) begin
            idle_q <= '0;
            if (!last_beat) beat_q <= beat_q + AW'(1);
            if (mism) begin
                err_q <= sat_inc(err_q);
                if (err_q == '0) begin
                    fidx_q <= beat_q;
                    fch_q  <= low_ch;
                end
            end
        end else if (state_q == CHECK) begin
            if (idle_hit) to_q <= 1'b1;
            else          idle_q <= idle_q + TW'(1);
        end
    end

    assign busy          = (state_q == SETTLE) || (state_q == CHECK);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == '0) && !to_q;
    assign timeout       = to_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_ch  = fch_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: a run-to-end and a stop-on-error instance share stimulus
// and are compared every cycle against a transaction-level model.
module tb_result_checker;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int VW    = 32;
    localparam int SET0  = 2;
    localparam int SET1  = 0;
    localparam int TMO0  = 40;
    localparam int TMO1  = 8;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          start       = 1'b0;
    logic          obs_valid   = 1'b0;
    logic [VW-1:0] obs_data    = '0;
    logic          exp_wr_en   = 1'b0;
    logic [3:0]    exp_wr_addr = '0;
    logic [VW-1:0] exp_wr_data = '0;

    logic [1:0] busy, done, pass, tmo;
    logic [4:0] errc [2];
    logic [3:0] fidx [2];
    logic [1:0] fch  [2];

    always #5 clk = ~clk;

    result_checker #(
        .NUM_CH(2), .DATA_W(DW), .DEPTH(DEPTH),
        .SETTLE_CYC(SET0), .TIMEOUT(TMO0), .STOP_ON_ERR(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .obs_valid(obs_valid), .obs_data(obs_data),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
        .err_count(errc[0]), .first_err_idx(fidx[0]), .first_err_ch(fch[0])
    );

    result_checker #(
        .NUM_CH(2), .DATA_W(DW), .DEPTH(DEPTH),
        .SETTLE_CYC(SET1), .TIMEOUT(TMO1), .STOP_ON_ERR(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .obs_valid(obs_valid), .obs_data(obs_data),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
        .err_count(errc[1]), .first_err_idx(fidx[1]), .first_err_ch(fch[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one record per instance
    logic [VW-1:0] gold [2][DEPTH];
    logic [VW-1:0] ld [DEPTH];
    bit m_run [2];
    bit m_fin [2];
    bit m_to  [2];
    int m_wait [2];
    int m_beats [2];
    int m_idle [2];
    int m_errs [2];
    int m_fidx [2];
    int m_fch [2];

    task automatic model_step(input int i, input int set_c, input int tmo_c, input bit soe);
        bit busy_m;
        int bad_ch;
        if (rst) begin
            m_run[i] = 0; m_fin[i] = 0; m_to[i] = 0; m_wait[i] = 0; m_beats[i] = 0;
            m_idle[i] = 0; m_errs[i] = 0; m_fidx[i] = 0; m_fch[i] = 0;
            return;
        end
        busy_m = m_run[i] && !m_fin[i];
        if (exp_wr_en && !busy_m) gold[i][exp_wr_addr] = exp_wr_data;
        if (!busy_m) begin
            if (start) begin
                m_run[i] = 1; m_fin[i] = 0; m_to[i] = 0; m_wait[i] = set_c; m_beats[i] = 0;
                m_idle[i] = 0; m_errs[i] = 0; m_fidx[i] = 0; m_fch[i] = 0;
            end
        end else if (m_wait[i] > 0) begin
            m_wait[i]--;
        end else if (obs_valid) begin
            bad_ch = -1;
            for (int c = 1; c >= 0; c--)
                if (obs_data[c*DW +: DW] != gold[i][m_beats[i]][c*DW +: DW]) bad_ch = c;
            m_idle[i] = 0;
            if (bad_ch >= 0) begin
                if (m_errs[i] == 0) begin
                    m_fidx[i] = m_beats[i];
                    m_fch[i]  = bad_ch;
                end
                m_errs[i]++;
            end
            m_beats[i]++;
            if (m_beats[i] == DEPTH || (soe && bad_ch >= 0)) m_fin[i] = 1;
        end else begin
            m_idle[i]++;
            if (m_idle[i] == tmo_c) begin
                m_to[i]  = 1;
                m_fin[i] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, SET0, TMO0, 1'b0);
        model_step(1, SET1, TMO1, 1'b1);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy%0d", i),    int'(busy[i]), int'(m_run[i] && !m_fin[i]));
            chk($sformatf("done%0d", i),    int'(done[i]), int'(m_fin[i]));
            chk($sformatf("pass%0d", i),    int'(pass[i]), int'(m_fin[i] && m_errs[i] == 0 && !m_to[i]));
            chk($sformatf("timeout%0d", i), int'(tmo[i]),  int'(m_to[i]));
            chk($sformatf("err_count%0d", i),     int'(errc[i]), m_errs[i]);
            chk($sformatf("first_err_idx%0d", i), int'(fidx[i]), m_fidx[i]);
            chk($sformatf("first_err_ch%0d", i),  int'(fch[i]),  m_fch[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [VW-1:0] d, input bit with_start);
        exp_wr_en   = 1'b1;
        exp_wr_addr = 4'(a);
        exp_wr_data = d;
        start       = with_start;
        ld[a]       = d;
        tick();
        exp_wr_en   = 1'b0;
        start       = 1'b0;
        if (with_start) repeat (SET0) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (SET0) tick();
    endtask

    task automatic beat(input int k, input logic [VW-1:0] flip);
        obs_valid = 1'b1;
        obs_data  = ld[k] ^ flip;
        tick();
        obs_valid = 1'b0;
        obs_data  = '0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done[0] && n < 200) begin
            tick();
            n++;
        end
        chk("wait_done", int'(done[0]), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), int'(busy[i]), 0);
            chk($sformatf("%s_done%0d", tag, i), int'(done[i]), 0);
            chk($sformatf("%s_pass%0d", tag, i), int'(pass[i]), 0);
            chk($sformatf("%s_tmo%0d", tag, i),  int'(tmo[i]),  0);
            chk($sformatf("%s_errc%0d", tag, i), int'(errc[i]), 0);
            chk($sformatf("%s_fidx%0d", tag, i), int'(fidx[i]), 0);
            chk($sformatf("%s_fch%0d", tag, i),  int'(fch[i]),  0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [VW-1:0] flip;

        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Matching pattern mem[i] = {i+0x100, i}, one beat per cycle
        for (int i = 0; i < DEPTH; i++) load(i, {16'(i + 'h100), 16'(i)}, 1'b0);
        do_start();
        for (int k = 0; k < DEPTH - 1; k++) beat(k, '0);
        chk("t1_done_before_last", int'(done[0]), 0);
        beat(DEPTH - 1, '0);
        chk("t1_done", int'(done[0]), 1);
        chk("t1_pass", int'(pass[0]), 1);
        chk("t1_errc", int'(errc[0]), 0);

        // Two corrupted beats
        do_start();
        for (int k = 0; k < DEPTH; k++)
            beat(k, (k == 5) ? 32'h0001_0000 : (k == 9) ? 32'h0000_8000 : 32'h0);
        wait_done(n);
        chk("t2_pass", int'(pass[0]), 0);
        chk("t2_errc", int'(errc[0]), 2);
        chk("t2_fidx", int'(fidx[0]), 5);
        chk("t2_fch",  int'(fch[0]),  1);
        chk("t2_soe_done", int'(done[1]), 1);
        chk("t2_soe_errc", int'(errc[1]), 1);
        chk("t2_soe_fidx", int'(fidx[1]), 5);

        // Stop on first error at beat 3
        do_start();
        for (int k = 0; k < 3; k++) beat(k, '0);
        chk("t3_soe_not_done", int'(done[1]), 0);
        beat(3, 32'h0000_0004);
        chk("t3_soe_done", int'(done[1]), 1);
        chk("t3_soe_errc", int'(errc[1]), 1);
        chk("t3_soe_fch",  int'(fch[1]),  0);
        for (int k = 4; k < DEPTH; k++) beat(k, '0);
        chk("t3_errc", int'(errc[0]), 1);

        // Beats stop after 4 -> timeout
        do_start();
        for (int k = 0; k < 4; k++) beat(k, '0);
        wait_done(n);
        chk("t4_latency", n, TMO0);
        chk("t4_timeout", int'(tmo[0]), 1);
        chk("t4_pass", int'(pass[0]), 0);
        chk("t4_soe_timeout", int'(tmo[1]), 1);

        // start and write during CHECK are ignored
        do_start();
        for (int k = 0; k < 6; k++) beat(k, '0);
        start = 1'b1; exp_wr_en = 1'b1; exp_wr_addr = 4'd12; exp_wr_data = ~ld[12];
        beat(6, '0);
        start = 1'b0; exp_wr_en = 1'b0;
        for (int k = 7; k < DEPTH; k++) beat(k, '0);
        wait_done(n);
        chk("t5_pass", int'(pass[0]), 1);
        chk("t5_soe_pass", int'(pass[1]), 1);

        // Reset during CHECK at beat 7, then rerun without reload
        do_start();
        for (int k = 0; k < 7; k++) beat(k, '0);
        obs_valid = 1'b1; obs_data = ld[7]; rst = 1'b1;
        tick();
        obs_valid = 1'b0; obs_data = '0;
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        do_start();
        for (int k = 0; k < DEPTH; k++) beat(k, '0);
        chk("t6_pass", int'(pass[0]), 1);

        // Randomised runs; final golden write shares its cycle with start
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) load(i, $urandom(), (i == DEPTH - 1));
            for (int k = 0; k < DEPTH; k++) begin
                repeat ($urandom_range(2, 0)) tick();
                flip = ($urandom_range(7, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
                beat(k, flip);
            end
            wait_done(n);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
